irda_mir_rx: RTL and testbench
==============================

Name: irda_mir_rx

Overview:
- MIR (1.152 Mb/s) HDLC-style receive framer.
- Takes the recovered serial bit stream, one bit per `mir_rxbit_enable` strobe.
- Per bit: hunts for 0x7E flags, removes stuffed zeros, detects aborts, assembles bytes LSB first and checks the CRC-CCITT16 FCS.
- Delivers payload bytes (FCS stripped) to the RX FIFO writer, with an end-of-frame status pulse.

Parameters:
- MAX_BYTES, 2050, maximum bytes (payload plus FCS) per frame; exceeding it is a frame error.
- CRC_RESIDUE, 16'hF0B8, good-frame CRC register value after the FCS has been shifted in.

Ports:
- clk  input  1  system clock
- wb_rst_n  input  1  asynchronous active-low reset
- rx_enable  input  1  receiver enable; low forces HUNT and clears the frame pipeline
- mir_rxbit_enable  input  1  one-clk strobe per received bit period
- mir_rx_i  input  1  recovered bit, valid when the strobe is high
- fifo_full  input  1  RX FIFO full
- rx_data  output  8  payload byte
- rx_data_valid  output  1  one-clk write strobe for rx_data
- rx_eof  output  1  one-clk end-of-frame pulse; the status outputs below are valid with it
- rx_crc_err  output  1  FCS residue mismatch
- rx_frame_err  output  1  short, misaligned or oversize frame
- rx_abort  output  1  seven or more consecutive ones inside a frame
- rx_overrun  output  1  a byte was dropped because fifo_full was high
- rx_frame_active  output  1  high from the first payload bit until the frame ends

Behaviour:
- Reset (wb_rst_n=0, asynchronous):
  - State HUNT; all counters, the delay line and the byte hold stage cleared.
  - CRC register = 16'hFFFF.
  - All outputs 0.
- Processing cadence:
  - All bit processing happens only on clk edges where mir_rxbit_enable=1 and rx_enable=1.
  - Pulse outputs (rx_data_valid, rx_eof) are registered and last exactly one clk.
- Bit classification, using a 3-bit saturating ones counter ones_c:
  - On a 1: ones_c++ (saturating). Reaching 7 is an abort.
  - On a 0 with ones_c==5: stuffed zero; discard it.
  - On a 0 with ones_c==6: flag.
  - Any other 0: data bit.
  - Every 0 clears ones_c.
- Destuff delay line (7 bits):
  - Data bits and ones are pushed into it, including the flag's leading 0 and its six 1s.
  - Only a bit displaced out of the line, after 7 pushes, enters the byte assembler and the CRC.
  - On a flag or abort the line is flushed without output.
- CRC:
  - Reflected polynomial 0x8408, preset FFFF, applied per assembled bit, LSB first.
  - Covers payload and FCS bits.
- Byte assembler:
  - 3-bit bit counter; 8-bit shift register filled LSB first.
  - On byte completion: byte_cnt++ (12 bits).
  - The byte enters a 2-deep hold stage. When the hold is already full, the oldest byte is emitted on rx_data with rx_data_valid, unless fifo_full is high.
  - If fifo_full is high: the byte is dropped and rx_overrun is set (sticky until the next rx_eof).
  - The two bytes left in the hold at the closing flag are the FCS and are never emitted.
- State machine:
  - HUNT: ignore everything until a flag → SYNC.
  - SYNC: after a flag, no bits assembled yet. Another flag stays in SYNC (inter-frame fill, two STA flags); no event is generated. The first displaced data bit → FRAME; rx_frame_active=1.
  - FRAME, on a flag:
    - if bit_cnt!=0, or byte_cnt<3, or byte_cnt>MAX_BYTES: rx_eof with rx_frame_err=1;
    - else rx_eof with rx_crc_err = (crc != CRC_RESIDUE);
    - then clear the counters, CRC and hold, and go to SYNC (the closing flag may open the next frame).
  - FRAME, on byte_cnt exceeding MAX_BYTES: rx_eof with rx_frame_err=1, then HUNT.
  - Any state, abort (ones_c reaches 7):
    - FRAME: rx_eof with rx_abort=1;
    - SYNC: silent, no event;
    - in both cases → HUNT. A constant-1 line (break) stays in HUNT.
- Status outputs: rx_crc_err, rx_frame_err and rx_abort hold their values until the next rx_eof; at most one of them is set per rx_eof.
- rx_enable deasserted mid-frame: immediate HUNT, no rx_eof, pipeline discarded.

Test Plan:
- Good frame: two flags, payload "123456789" (0x31..0x39), FCS bytes 0x6E,0x90, then a flag → nine rx_data_valid pulses 0x31..0x39 in order, then rx_eof with all error flags 0 and rx_overrun=0.
- Stuffing: payload 0xFF,0x7E,0x3F with a correct FCS, stuffed zeros inserted after every five ones → those three bytes output exactly, rx_eof with no errors; no false flag or abort.
- Bad CRC: the good frame with FCS 0x6F,0x90 → nine bytes output, rx_eof with rx_crc_err=1.
- Abort and break:
  - flag, three data bytes, then eight 1s → rx_eof with rx_abort=1, state HUNT;
  - a following 32 idle 1s produce no events;
  - the next valid frame is received cleanly.
- Frame errors:
  - flag, two bytes, flag → rx_eof with rx_frame_err=1 and no rx_data_valid;
  - flag, 21 bits, flag → rx_eof with rx_frame_err=1;
  - flag, flag, flag → no events.
- Overrun and reset:
  - fifo_full high during byte 4 of the good frame → 8 bytes written, rx_eof with rx_overrun=1;
  - wb_rst_n pulsed low mid-frame → all outputs 0 immediately, HUNT, the next frame is received correctly.

Source files
------------

// File: rtl/irda_mir_rx_if.sv
// Signal bundle between the MIR receive framer and its bit source / RX FIFO writer.
interface irda_mir_rx_if;
    logic       rx_enable;
    logic       mir_rxbit_enable;
    logic       mir_rx_i;
    logic       fifo_full;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_eof;
    logic       rx_crc_err;
    logic       rx_frame_err;
    logic       rx_abort;
    logic       rx_overrun;
    logic       rx_frame_active;

    // Framer side: consumes the bit stream, produces bytes and frame status.
    modport master (
        input  rx_enable,
        input  mir_rxbit_enable,
        input  mir_rx_i,
        input  fifo_full,
        output rx_data,
        output rx_data_valid,
        output rx_eof,
        output rx_crc_err,
        output rx_frame_err,
        output rx_abort,
        output rx_overrun,
        output rx_frame_active
    );

    // Environment side: supplies bits and FIFO state, receives bytes and status.
    modport slave (
        output rx_enable,
        output mir_rxbit_enable,
        output mir_rx_i,
        output fifo_full,
        input  rx_data,
        input  rx_data_valid,
        input  rx_eof,
        input  rx_crc_err,
        input  rx_frame_err,
        input  rx_abort,
        input  rx_overrun,
        input  rx_frame_active
    );
endinterface

// File: rtl/irda_mir_rx.sv
// MIR HDLC receive framer: flag hunt, zero destuffing, abort detection,
// LSB-first byte assembly, CRC-CCITT16 check and FCS stripping.
module irda_mir_rx #(
    parameter int unsigned MAX_BYTES   = 2050,
    parameter logic [15:0] CRC_RESIDUE = 16'hF0B8
) (
    input  logic          clk,
    input  logic          wb_rst_n,
    irda_mir_rx_if.master rx_bus
);

    localparam int unsigned ONES_W   = 3;
    localparam int unsigned DL_W     = 7;
    localparam int unsigned FILL_W   = 3;
    localparam int unsigned BIT_W    = 3;
    localparam int unsigned BYTE_W   = 12;
    localparam int unsigned CRC_W    = 16;
    localparam logic [15:0] CRC_POLY = 16'h8408;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        SYNC  = 2'd1,
        FRAME = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ONES_W-1:0]   ones_q, ones_d;
    logic [DL_W-1:0]     dl_q, dl_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [7:0]          sr_q, sr_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [CRC_W-1:0]    crc_q, crc_d;
    logic [7:0]          hold0_q, hold0_d;
    logic [7:0]          hold1_q, hold1_d;
    logic [1:0]          hold_cnt_q, hold_cnt_d;
    logic                ovr_frame_q, ovr_frame_d;
    logic [7:0]          rx_data_q, rx_data_d;
    logic                valid_q, valid_d;
    logic                eof_q, eof_d;
    logic                crc_err_q, crc_err_d;
    logic                frame_err_q, frame_err_d;
    logic                abort_q, abort_d;
    logic                overrun_q, overrun_d;
    logic                active_q, active_d;

    logic                is_flag, is_abort, push, out_vld, out_bit, fb, byte_done, clr_frame;
    logic [7:0]          new_byte;

    // State and datapath registers.
    always_ff @(posedge clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q     <= HUNT;
            ones_q      <= '0;
            dl_q        <= '0;
            fill_q      <= '0;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            crc_q       <= CRC_INIT;
            hold0_q     <= '0;
            hold1_q     <= '0;
            hold_cnt_q  <= '0;
            ovr_frame_q <= 1'b0;
            rx_data_q   <= '0;
            valid_q     <= 1'b0;
            eof_q       <= 1'b0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            abort_q     <= 1'b0;
            overrun_q   <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ones_q      <= ones_d;
            dl_q        <= dl_d;
            fill_q      <= fill_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            crc_q       <= crc_d;
            hold0_q     <= hold0_d;
            hold1_q     <= hold1_d;
            hold_cnt_q  <= hold_cnt_d;
            ovr_frame_q <= ovr_frame_d;
            rx_data_q   <= rx_data_d;
            valid_q     <= valid_d;
            eof_q       <= eof_d;
            crc_err_q   <= crc_err_d;
            frame_err_q <= frame_err_d;
            abort_q     <= abort_d;
            overrun_q   <= overrun_d;
            active_q    <= active_d;
        end
    end

    // Per-bit classification, destuff line, assembler, hold stage and frame FSM.
    always_comb begin
        state_d     = state_q;
        ones_d      = ones_q;
        dl_d        = dl_q;
        fill_d      = fill_q;
        sr_d        = sr_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        crc_d       = crc_q;
        hold0_d     = hold0_q;
        hold1_d     = hold1_q;
        hold_cnt_d  = hold_cnt_q;
        ovr_frame_d = ovr_frame_q;
        rx_data_d   = rx_data_q;
        valid_d     = 1'b0;
        eof_d       = 1'b0;
        crc_err_d   = crc_err_q;
        frame_err_d = frame_err_q;
        abort_d     = abort_q;
        overrun_d   = overrun_q;
        active_d    = active_q;
        is_flag     = 1'b0;
        is_abort    = 1'b0;
        push        = 1'b0;
        out_vld     = 1'b0;
        out_bit     = 1'b0;
        fb          = 1'b0;
        byte_done   = 1'b0;
        clr_frame   = 1'b0;
        new_byte    = sr_q;

        if (!rx_bus.rx_enable) begin
            state_d   = HUNT;
            ones_d    = '0;
            active_d  = 1'b0;
            clr_frame = 1'b1;
        end else if (rx_bus.mir_rxbit_enable) begin
            // Ones run classification; a 0 after five 1s is a stuffed bit.
            if (rx_bus.mir_rx_i) begin
                ones_d   = (ones_q == 3'd7) ? 3'd7 : ones_q + 3'd1;
                is_abort = (ones_q >= 3'd6);
                push     = !is_abort;
            end else begin
                ones_d  = '0;
                is_flag = (ones_q == 3'd6);
                push    = (ones_q != 3'd5) && (ones_q != 3'd6);
            end

            // Seven-bit delay hides the flag prefix; only displaced bits are payload.
            if (push && (state_q != HUNT)) begin
                dl_d = {dl_q[DL_W-2:0], rx_bus.mir_rx_i};
                if (fill_q == FILL_W'(DL_W)) begin
                    out_vld = 1'b1;
                    out_bit = dl_q[DL_W-1];
                end else begin
                    fill_d = fill_q + 3'd1;
                end
            end

            if (out_vld) begin
                fb        = crc_q[0] ^ out_bit;
                crc_d     = {1'b0, crc_q[CRC_W-1:1]} ^ (fb ? CRC_POLY : 16'h0000);
                sr_d      = {out_bit, sr_q[7:1]};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (state_q == SYNC) begin
                    state_d  = FRAME;
                    active_d = 1'b1;
                end
                if (bit_cnt_q == 3'd7) begin
                    byte_done  = 1'b1;
                    new_byte   = {out_bit, sr_q[7:1]};
                    byte_cnt_d = byte_cnt_q + 12'd1;
                end
            end

            // The hold keeps the latest two bytes back so the FCS is never emitted.
            if (byte_done) begin
                if (byte_cnt_q >= BYTE_W'(MAX_BYTES)) begin
                    eof_d       = 1'b1;
                    crc_err_d   = 1'b0;
                    frame_err_d = 1'b1;
                    abort_d     = 1'b0;
                    overrun_d   = ovr_frame_q;
                    state_d     = HUNT;
                    active_d    = 1'b0;
                    clr_frame   = 1'b1;
                end else begin
                    case (hold_cnt_q)
                        2'd0: begin
                            hold0_d    = new_byte;
                            hold_cnt_d = 2'd1;
                        end
                        2'd1: begin
                            hold1_d    = new_byte;
                            hold_cnt_d = 2'd2;
                        end
                        default: begin
                            if (rx_bus.fifo_full) begin
                                ovr_frame_d = 1'b1;
                                overrun_d   = 1'b1;
                            end else begin
                                rx_data_d = hold0_q;
                                valid_d   = 1'b1;
                            end
                            hold0_d = hold1_q;
                            hold1_d = new_byte;
                        end
                    endcase
                end
            end

            // Closing flag ends the frame and may open the next one.
            if (is_flag) begin
                clr_frame = 1'b1;
                state_d   = SYNC;
                if (state_q == FRAME) begin
                    eof_d     = 1'b1;
                    abort_d   = 1'b0;
                    overrun_d = ovr_frame_q;
                    active_d  = 1'b0;
                    if ((bit_cnt_q != '0) || (byte_cnt_q < 12'd3) ||
                        (byte_cnt_q > BYTE_W'(MAX_BYTES))) begin
                        frame_err_d = 1'b1;
                        crc_err_d   = 1'b0;
                    end else begin
                        frame_err_d = 1'b0;
                        crc_err_d   = (crc_q != CRC_RESIDUE);
                    end
                end
            end

            // Seven ones kill any frame; in SYNC it is dropped silently.
            if (is_abort && (state_q != HUNT)) begin
                clr_frame = 1'b1;
                state_d   = HUNT;
                active_d  = 1'b0;
                if (state_q == FRAME) begin
                    eof_d       = 1'b1;
                    abort_d     = 1'b1;
                    crc_err_d   = 1'b0;
                    frame_err_d = 1'b0;
                    overrun_d   = ovr_frame_q;
                end
            end
        end

        if (clr_frame) begin
            dl_d        = '0;
            fill_d      = '0;
            sr_d        = '0;
            bit_cnt_d   = '0;
            byte_cnt_d  = '0;
            crc_d       = CRC_INIT;
            hold0_d     = '0;
            hold1_d     = '0;
            hold_cnt_d  = '0;
            ovr_frame_d = 1'b0;
        end
    end

    assign rx_bus.rx_data         = rx_data_q;
    assign rx_bus.rx_data_valid   = valid_q;
    assign rx_bus.rx_eof          = eof_q;
    assign rx_bus.rx_crc_err      = crc_err_q;
    assign rx_bus.rx_frame_err    = frame_err_q;
    assign rx_bus.rx_abort        = abort_q;
    assign rx_bus.rx_overrun      = overrun_q;
    assign rx_bus.rx_frame_active = active_q;

endmodule

// File: tb/tb_irda_mir_rx.sv
// Directed testbench for the MIR receive framer.
module tb_irda_mir_rx;

    logic clk = 1'b0;
    logic wb_rst_n = 1'b0;

    irda_mir_rx_if bus ();

    irda_mir_rx dut (
        .clk      (clk),
        .wb_rst_n (wb_rst_n),
        .rx_bus   (bus)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] pl_q[$];
    int         eof_cnt = 0;
    int         got_base = 0;
    int         eof_base = 0;
    logic       st_crc, st_fr, st_ab, st_ov;
    int         tx_ones = 0;
    logic [15:0] fcs;

    // Output monitor: collect written bytes and end-of-frame status.
    always @(negedge clk) begin
        if (bus.rx_data_valid) got_q.push_back(bus.rx_data);
        if (bus.rx_eof) begin
            eof_cnt = eof_cnt + 1;
            st_crc  = bus.rx_crc_err;
            st_fr   = bus.rx_frame_err;
            st_ab   = bus.rx_abort;
            st_ov   = bus.rx_overrun;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " rx_data"},         32'(bus.rx_data), 32'h0);
        check({tag, " rx_data_valid"},   32'(bus.rx_data_valid), 32'h0);
        check({tag, " rx_eof"},          32'(bus.rx_eof), 32'h0);
        check({tag, " rx_crc_err"},      32'(bus.rx_crc_err), 32'h0);
        check({tag, " rx_frame_err"},    32'(bus.rx_frame_err), 32'h0);
        check({tag, " rx_abort"},        32'(bus.rx_abort), 32'h0);
        check({tag, " rx_overrun"},      32'(bus.rx_overrun), 32'h0);
        check({tag, " rx_frame_active"}, 32'(bus.rx_frame_active), 32'h0);
    endtask

    task automatic mark();
        got_base = got_q.size();
        eof_base = eof_cnt;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tx_bit(input logic b);
        @(negedge clk);
        bus.mir_rx_i         = b;
        bus.mir_rxbit_enable = 1'b1;
        @(negedge clk);
        bus.mir_rxbit_enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic tx_flag();
        logic [7:0] f;
        f = 8'h7E;
        for (int i = 0; i < 8; i++) tx_bit(f[i]);
        tx_ones = 0;
    endtask

    // LSB first with a zero inserted after every five consecutive ones.
    task automatic tx_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            tx_bit(b[i]);
            if (b[i]) begin
                tx_ones++;
                if (tx_ones == 5) begin
                    tx_bit(1'b0);
                    tx_ones = 0;
                end
            end else begin
                tx_ones = 0;
            end
        end
    endtask

    function automatic logic [15:0] calc_fcs();
        logic [15:0] c;
        logic        f;
        c = 16'hFFFF;
        foreach (pl_q[i]) begin
            for (int j = 0; j < 8; j++) begin
                f = c[0] ^ pl_q[i][j];
                c = {1'b0, c[15:1]} ^ (f ? 16'h8408 : 16'h0000);
            end
        end
        return ~c;
    endfunction

    task automatic load_good();
        pl_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    endtask

    task automatic send_frame(input string tag, input logic [7:0] lo, input logic [7:0] hi);
        tx_flag();
        tx_flag();
        foreach (pl_q[i]) tx_byte(pl_q[i]);
        check({tag, " active mid-frame"}, 32'(bus.rx_frame_active), 32'h1);
        tx_byte(lo);
        tx_byte(hi);
        tx_flag();
        idle(8);
        check({tag, " active after"}, 32'(bus.rx_frame_active), 32'h0);
    endtask

    task automatic verify(input string tag, input int exp_eofs,
                          input logic e_crc, input logic e_fr, input logic e_ab, input logic e_ov);
        int n;
        n = got_q.size() - got_base;
        check({tag, " byte count"}, 32'(n), 32'(exp_q.size()));
        for (int i = 0; (i < exp_q.size()) && (i < n); i++)
            check($sformatf("%s byte%0d", tag, i), 32'(got_q[got_base + i]), 32'(exp_q[i]));
        check({tag, " eof count"}, 32'(eof_cnt - eof_base), 32'(exp_eofs));
        if (exp_eofs > 0) begin
            check({tag, " crc_err"},   32'(st_crc), 32'(e_crc));
            check({tag, " frame_err"}, 32'(st_fr),  32'(e_fr));
            check({tag, " abort"},     32'(st_ab),  32'(e_ab));
            check({tag, " overrun"},   32'(st_ov),  32'(e_ov));
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bus.rx_enable        = 1'b0;
        bus.mir_rxbit_enable = 1'b0;
        bus.mir_rx_i         = 1'b0;
        bus.fifo_full        = 1'b0;
        idle(3);
        check_idle("reset");
        wb_rst_n      = 1'b1;
        bus.rx_enable = 1'b1;
        idle(4);

        // Good frame "123456789" with FCS 0x6E,0x90.
        load_good();
        mark();
        send_frame("good", 8'h6E, 8'h90);
        exp_q = pl_q;
        verify("good", 1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Payload needing stuffed zeros.
        pl_q = '{8'hFF, 8'h7E, 8'h3F};
        fcs  = calc_fcs();
        mark();
        send_frame("stuff", fcs[7:0], fcs[15:8]);
        exp_q = pl_q;
        verify("stuff", 1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Corrupted FCS.
        load_good();
        mark();
        send_frame("badcrc", 8'h6F, 8'h90);
        exp_q = pl_q;
        verify("badcrc", 1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Abort after three bytes, then a break, then a clean frame.
        mark();
        tx_flag();
        tx_byte(8'h31);
        tx_byte(8'h32);
        tx_byte(8'h33);
        repeat (8) tx_bit(1'b1);
        idle(8);
        exp_q.delete();
        verify("abort", 1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("abort active", 32'(bus.rx_frame_active), 32'h0);
        mark();
        repeat (32) tx_bit(1'b1);
        idle(8);
        verify("break", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        load_good();
        mark();
        send_frame("after_abort", 8'h6E, 8'h90);
        exp_q = pl_q;
        verify("after_abort", 1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Short frame: two bytes.
        mark();
        tx_flag();
        tx_byte(8'h31);
        tx_byte(8'h32);
        tx_flag();
        idle(8);
        exp_q.delete();
        verify("short", 1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Misaligned frame: 21 bits.
        mark();
        tx_flag();
        tx_byte(8'h31);
        tx_byte(8'h32);
        tx_bit(1'b1);
        tx_bit(1'b0);
        tx_bit(1'b1);
        tx_bit(1'b0);
        tx_bit(1'b1);
        tx_flag();
        idle(8);
        verify("misaligned", 1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Back-to-back flags only.
        mark();
        tx_flag();
        tx_flag();
        tx_flag();
        idle(8);
        verify("flags_only", 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // FIFO full while byte 4 would be written.
        load_good();
        mark();
        tx_flag();
        tx_flag();
        foreach (pl_q[i]) begin
            bus.fifo_full = (i == 6);
            tx_byte(pl_q[i]);
        end
        bus.fifo_full = 1'b0;
        tx_byte(8'h6E);
        tx_byte(8'h90);
        tx_flag();
        idle(8);
        exp_q = '{8'h31, 8'h32, 8'h33, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        verify("overrun", 1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a frame.
        check("pre-reset overrun", 32'(bus.rx_overrun), 32'h1);
        tx_flag();
        tx_flag();
        tx_byte(8'h31);
        tx_byte(8'h32);
        tx_byte(8'h33);
        tx_byte(8'h34);
        check("pre-reset active", 32'(bus.rx_frame_active), 32'h1);
        @(negedge clk);
        wb_rst_n = 1'b0;
        #1;
        check_idle("midreset");
        @(negedge clk);
        wb_rst_n = 1'b1;
        tx_ones  = 0;
        load_good();
        mark();
        send_frame("post_reset", 8'h6E, 8'h90);
        exp_q = pl_q;
        verify("post_reset", 1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Receiver disabled mid-frame: frame silently discarded.
        tx_flag();
        tx_flag();
        tx_byte(8'h31);
        tx_byte(8'h32);
        tx_byte(8'h33);
        tx_byte(8'h34);
        bus.rx_enable = 1'b0;
        idle(4);
        check("disabled active", 32'(bus.rx_frame_active), 32'h0);
        mark();
        tx_byte(8'h35);
        tx_flag();
        idle(8);
        exp_q.delete();
        verify("disabled", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.rx_enable = 1'b1;
        idle(4);
        load_good();
        mark();
        send_frame("post_enable", 8'h6E, 8'h90);
        exp_q = pl_q;
        verify("post_enable", 1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
